// File: rtl/hpdcache_demux_reg.sv
// ============================================================================
// Module   : hpdcache_demux_reg
// Brief    : 1-to-NOUTPUT demultiplexer with a single-entry register per output.
//            Optional macro HPDCACHE_DEMUX_REG_DROP_CNT_EN adds a saturating
//            illegal-selector drop counter (drop_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_demux_reg #(
    parameter int unsigned NOUTPUT     = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter bit          ONE_HOT_SEL = 1'b0,
    localparam int unsigned SEL_WIDTH  = ONE_HOT_SEL ? NOUTPUT
                                       : ((NOUTPUT > 1) ? $clog2(NOUTPUT) : 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,

    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [SEL_WIDTH-1:0]                 in_sel_i,
    input  logic [DATA_WIDTH-1:0]                in_data_i,

    output logic [NOUTPUT-1:0]                   out_valid_o,
    input  logic [NOUTPUT-1:0]                   out_ready_i,
    output logic [NOUTPUT-1:0][DATA_WIDTH-1:0]   out_data_o,
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
    output logic [7:0]                           drop_cnt_o,
`endif
    output logic                                 err_o
);

    logic [NOUTPUT-1:0]                 r_valid;
    logic [NOUTPUT-1:0][DATA_WIDTH-1:0] r_data;
    logic                               r_err;

    logic [NOUTPUT-1:0] w_dec;
    logic               w_legal;
    logic               w_ready_sel;
    logic               w_accept;
    logic [NOUTPUT-1:0] w_load;
    logic [NOUTPUT-1:0] w_drain;

    // w_dec is the one-hot destination; it is all-zero for an illegal binary selector
    generate
        if (NOUTPUT == 1) begin : g_single
            assign w_dec   = 1'b1;
            assign w_legal = 1'b1;
        end else if (ONE_HOT_SEL) begin : g_onehot
            assign w_dec   = in_sel_i;
            assign w_legal = $onehot(in_sel_i);
        end else begin : g_binary
            for (genvar k = 0; k < NOUTPUT; k++) begin : g_dec
                assign w_dec[k] = (32'(in_sel_i) == k);
            end
            assign w_legal = |w_dec;
        end
    endgenerate

    assign w_ready_sel = |(w_dec & (~r_valid | out_ready_i));
    assign in_ready_o  = !rst_i && (!w_legal || w_ready_sel);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_load      = {NOUTPUT{w_accept && w_legal}} & w_dec;
    assign w_drain     = r_valid & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_load | (r_valid & ~w_drain);
            r_err   <= w_accept && !w_legal;
        end
    end

    // Payload registers carry no reset; validity alone qualifies them
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NOUTPUT; k++) begin
            if (w_load[k]) begin
                r_data[k] <= in_data_i;
            end
        end
    end

`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt <= 8'd0;
        end else if (w_accept && !w_legal && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`endif

    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_demux_reg.sv
// ============================================================================
// Module   : tb_hpdcache_demux_reg
// Brief    : Self-checking bench: three demux configurations against a
//            queue-based reference model, directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpdcache_demux_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Per-DUT stimulus: 0 = NOUTPUT 4 binary, 1 = NOUTPUT 3 binary, 2 = NOUTPUT 4 one-hot
    logic        in_v [3];
    logic [3:0]  in_s [3];
    logic [31:0] in_d [3];
    logic [3:0]  in_r [3];

    logic            rdy0, rdy1, rdy2;
    logic            err0, err1, err2;
    logic [3:0]      ov0, ov2;
    logic [2:0]      ov1;
    logic [3:0][31:0] od0, od2;
    logic [2:0][31:0] od1;
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
    logic [7:0]      cnt0, cnt1, cnt2;
`endif

    hpdcache_demux_reg #(.NOUTPUT(4), .DATA_WIDTH(32), .ONE_HOT_SEL(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_v[0]), .in_ready_o(rdy0), .in_sel_i(in_s[0][1:0]), .in_data_i(in_d[0]),
        .out_valid_o(ov0), .out_ready_i(in_r[0]), .out_data_o(od0),
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
        .drop_cnt_o(cnt0),
`endif
        .err_o(err0)
    );

    hpdcache_demux_reg #(.NOUTPUT(3), .DATA_WIDTH(32), .ONE_HOT_SEL(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_v[1]), .in_ready_o(rdy1), .in_sel_i(in_s[1][1:0]), .in_data_i(in_d[1]),
        .out_valid_o(ov1), .out_ready_i(in_r[1][2:0]), .out_data_o(od1),
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
        .drop_cnt_o(cnt1),
`endif
        .err_o(err1)
    );

    hpdcache_demux_reg #(.NOUTPUT(4), .DATA_WIDTH(32), .ONE_HOT_SEL(1'b1)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_v[2]), .in_ready_o(rdy2), .in_sel_i(in_s[2]), .in_data_i(in_d[2]),
        .out_valid_o(ov2), .out_ready_i(in_r[2]), .out_data_o(od2),
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
        .drop_cnt_o(cnt2),
`endif
        .err_o(err2)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: one FIFO per output of each DUT (capacity one entry)
    logic [31:0] mq [12][$];
    logic        exp_err [3];
    int          exp_cnt [3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int nout(input int d);
        return (d == 1) ? 3 : 4;
    endfunction

    function automatic logic get_rdy(input int d);
        case (d)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_err(input int d);
        case (d)
            0:       return err0;
            1:       return err1;
            default: return err2;
        endcase
    endfunction

    function automatic logic [3:0] get_v(input int d);
        case (d)
            0:       return ov0;
            1:       return {1'b0, ov1};
            default: return ov2;
        endcase
    endfunction

    function automatic logic [31:0] get_d(input int d, input int k);
        if (d == 0) return od0[k];
        if (d == 2) return od2[k];
        case (k)
            0:       return od1[0];
            1:       return od1[1];
            default: return od1[2];
        endcase
    endfunction

`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
    function automatic logic [7:0] get_cnt(input int d);
        case (d)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction
`endif

    // Selector meaning from first principles: binary index or position of the single set bit
    task automatic decode(input int d, output bit legal, output int idx);
        idx = 0;
        if (d == 2) begin
            legal = ($countones(in_s[d]) == 1);
            for (int k = 0; k < 4; k++) if (in_s[d][k]) idx = k;
        end else begin
            idx   = int'(in_s[d]);
            legal = (idx < nout(d));
        end
    endtask

    // Called just after a negedge with inputs driven; checks, advances the model, returns at next negedge
    task automatic step();
        bit   legal [3];
        int   idx   [3];
        logic erdy  [3];
        #1;
        for (int d = 0; d < 3; d++) begin
            decode(d, legal[d], idx[d]);
            if (rst)            erdy[d] = 1'b0;
            else if (!legal[d]) erdy[d] = 1'b1;
            else                erdy[d] = (mq[d*4+idx[d]].size() == 0) || in_r[d][idx[d]];
            check_eq($sformatf("d%0d_in_ready", d), {31'd0, get_rdy(d)}, {31'd0, erdy[d]});
            check_eq($sformatf("d%0d_err", d), {31'd0, get_err(d)}, {31'd0, exp_err[d]});
            for (int k = 0; k < nout(d); k++) begin
                check_eq($sformatf("d%0d_valid%0d", d, k), {31'd0, get_v(d)[k]},
                         {31'd0, mq[d*4+k].size() != 0});
                if (mq[d*4+k].size() != 0)
                    check_eq($sformatf("d%0d_data%0d", d, k), get_d(d, k), mq[d*4+k][0]);
            end
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
            check_eq($sformatf("d%0d_drop_cnt", d), {24'd0, get_cnt(d)}, exp_cnt[d]);
`endif
        end
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) mq[d*4+k].delete();
                exp_err[d] = 1'b0;
                exp_cnt[d] = 0;
            end else begin
                for (int k = 0; k < nout(d); k++)
                    if (mq[d*4+k].size() != 0 && in_r[d][k]) void'(mq[d*4+k].pop_front());
                exp_err[d] = in_v[d] && erdy[d] && !legal[d];
                if (in_v[d] && erdy[d] && legal[d]) mq[d*4+idx[d]].push_back(in_d[d]);
                if (exp_err[d] && exp_cnt[d] < 255) exp_cnt[d]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            in_v[d] = 1'b0;
            in_s[d] = 4'd0;
            in_d[d] = $urandom;
            in_r[d] = 4'hF;
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            exp_err[d] = 1'b0;
            exp_cnt[d] = 0;
        end
        idle_all();
        for (int d = 0; d < 3; d++) in_v[d] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        idle_all();
        step();

        // Single beat to output 2 appears one cycle later, others idle
        in_v[0] = 1'b1; in_s[0] = 4'd2; in_d[0] = 32'hA5;
        step();
        in_v[0] = 1'b0;
        #1;
        check_eq("a5_valid", {28'd0, ov0}, 32'h4);
        check_eq("a5_data", od0[2], 32'hA5);
        step();

        // Two beats to a stalled output 1: first held, second waits, order kept
        in_r[0] = 4'b1101;
        in_v[0] = 1'b1; in_s[0] = 4'd1; in_d[0] = 32'hB1;
        step();
        in_d[0] = 32'hB2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_ready", {31'd0, rdy0}, 32'd0);
            check_eq("stall_hold", od0[1], 32'hB1);
            step();
        end
        in_r[0] = 4'hF;
        #1;
        check_eq("release_ready", {31'd0, rdy0}, 32'd1);
        step();
        in_v[0] = 1'b0;
        #1;
        check_eq("second_beat", od0[1], 32'hB2);
        step();

        // Back-to-back stream to output 3
        for (int i = 0; i < 8; i++) begin
            in_v[0] = 1'b1; in_s[0] = 4'd3; in_d[0] = 32'h300 + i;
            #1;
            check_eq("stream_ready", {31'd0, rdy0}, 32'd1);
            step();
        end
        in_v[0] = 1'b0;
        step();

        // Illegal selectors: binary 3 of 3 outputs, non-one-hot 0110
        in_v[1] = 1'b1; in_s[1] = 4'd3;
        in_v[2] = 1'b1; in_s[2] = 4'b0110;
        #1;
        check_eq("illegal_ready_bin", {31'd0, rdy1}, 32'd1);
        check_eq("illegal_ready_oh", {31'd0, rdy2}, 32'd1);
        step();
        in_v[1] = 1'b0; in_v[2] = 1'b0;
        #1;
        check_eq("illegal_err_bin", {31'd0, err1}, 32'd1);
        check_eq("illegal_err_oh", {31'd0, err2}, 32'd1);
        check_eq("illegal_nov_bin", {29'd0, ov1}, 32'd0);
        check_eq("illegal_nov_oh", {28'd0, ov2}, 32'd0);
        step();
        #1;
        check_eq("err_one_pulse", {31'd0, err1}, 32'd0);
`ifdef HPDCACHE_DEMUX_REG_DROP_CNT_EN
        in_v[1] = 1'b1; in_s[1] = 4'd3;
        for (int i = 0; i < 300; i++) step();
        in_v[1] = 1'b0;
        step();
        #1;
        check_eq("drop_cnt_sat", {24'd0, cnt1}, 32'd255);
`endif
        step();

        // Reset while outputs 0 and 2 hold stalled entries
        in_r[0] = 4'b1010;
        in_v[0] = 1'b1; in_s[0] = 4'd0; in_d[0] = 32'hC0;
        step();
        in_s[0] = 4'd2; in_d[0] = 32'hC2;
        step();
        in_v[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", {28'd0, ov0}, 32'd0);
        check_eq("rst_err", {31'd0, err0}, 32'd0);
        in_r[0] = 4'hF;
        in_v[0] = 1'b1; in_s[0] = 4'd0; in_d[0] = 32'hD0;
        step();
        in_v[0] = 1'b0;
        #1;
        check_eq("post_rst_data", od0[0], 32'hD0);
        step();

        // Randomized traffic on all three configurations
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int d = 0; d < 3; d++) begin
                in_v[d] = ($urandom_range(0, 3) != 0);
                in_d[d] = $urandom;
                in_r[d] = 4'($urandom);
                if (d == 2)
                    in_s[d] = ($urandom_range(0, 3) != 0) ? (4'd1 << $urandom_range(0, 3))
                                                          : 4'($urandom);
                else
                    in_s[d] = 4'($urandom_range(0, 3));
            end
            step();
        end
        rst = 1'b0;
        idle_all();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
